// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM sample feeder and its FIFO.
package pwm_pkg;

  localparam int PWM_N_DEFAULT = 8;
  localparam int UFLOW_CNT_W   = 16;

  typedef logic [PWM_N_DEFAULT-1:0] pwm_level_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with a show-ahead head output and an occupancy count.
module sample_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pwm_sample_feeder.sv
// Buffers samples and hands one to the PWM as duty at each period boundary.
// Optional saturating underflow counter: define PWM_FEEDER_UNDERFLOW_CNT_EN.
module pwm_sample_feeder
  import pwm_pkg::*;
#(
  parameter int N        = PWM_N_DEFAULT,
  parameter int DEPTH    = 4,
  parameter int PRESCALE = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     in_valid,
  input  logic [N-1:0]             in_data,
  output logic                     in_ready,
  output logic                     step,
  output logic [N-1:0]             duty,
  output logic                     period_start,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   level
`ifdef PWM_FEEDER_UNDERFLOW_CNT_EN
  ,
  output logic [UFLOW_CNT_W-1:0]   underflow_count
`endif
);

  localparam int               CNT_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
  localparam logic [N-1:0]     PHASE_LAST = {N{1'b1}};

  logic [CNT_W-1:0] presc_q, presc_d;
  logic             step_q, step_d;
  logic [N-1:0]     phase_q, phase_d;
  logic [N-1:0]     duty_q, duty_d;
  logic             period_start_q, period_start_d;
  logic             underflow_q, underflow_d;

  logic             boundary;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [N-1:0]     fifo_head;

  sample_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // Acceptance looks only at the registered full flag, never at a same-cycle pop.
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;

  // The phase counter tracks the downstream PWM counter; its last step ends the period.
  assign boundary = step_q && (phase_q == PHASE_LAST);
  assign fifo_pop = boundary && !fifo_empty;

  always_comb begin
    presc_d = presc_q;
    step_d  = 1'b0;
    if (ena) begin
      step_d  = (presc_q == CNT_LAST);
      presc_d = step_d ? '0 : presc_q + 1'b1;
    end
  end

  always_comb begin
    phase_d        = step_q ? phase_q + 1'b1 : phase_q;
    duty_d         = fifo_pop ? fifo_head : duty_q;
    period_start_d = boundary;
    underflow_d    = boundary && fifo_empty;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q        <= '0;
      step_q         <= 1'b0;
      phase_q        <= '0;
      duty_q         <= '0;
      period_start_q <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      step_q         <= step_d;
      phase_q        <= phase_d;
      duty_q         <= duty_d;
      period_start_q <= period_start_d;
      underflow_q    <= underflow_d;
    end
  end

  assign step         = step_q;
  assign duty         = duty_q;
  assign period_start = period_start_q;
  assign underflow    = underflow_q;

`ifdef PWM_FEEDER_UNDERFLOW_CNT_EN
  logic [UFLOW_CNT_W-1:0] uflow_cnt_q, uflow_cnt_d;

  always_comb begin
    uflow_cnt_d = uflow_cnt_q;
    if (underflow_q && (uflow_cnt_q != {UFLOW_CNT_W{1'b1}})) begin
      uflow_cnt_d = uflow_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uflow_cnt_q <= '0;
    end else begin
      uflow_cnt_q <= uflow_cnt_d;
    end
  end

  assign underflow_count = uflow_cnt_q;
`endif

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Directed bench for pwm_sample_feeder with N=4, DEPTH=4, PRESCALE=2 (32-cycle period).
module tb_pwm_sample_feeder;

  localparam int N        = 4;
  localparam int DEPTH    = 4;
  localparam int PRESCALE = 2;

  logic                   clk;
  logic                   rst;
  logic                   ena;
  logic                   in_valid;
  logic [N-1:0]           in_data;
  logic                   in_ready;
  logic                   step;
  logic [N-1:0]           duty;
  logic                   period_start;
  logic                   underflow;
  logic [$clog2(DEPTH):0] level;
`ifdef PWM_FEEDER_UNDERFLOW_CNT_EN
  logic [15:0]            underflow_count;
`endif

  int vectors;
  int miscompares;
  int cyc;

  pwm_sample_feeder #(
    .N        (N),
    .DEPTH    (DEPTH),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .step         (step),
    .duty         (duty),
    .period_start (period_start),
    .underflow    (underflow),
    .level        (level)
`ifdef PWM_FEEDER_UNDERFLOW_CNT_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [N-1:0] burst [5];
    burst[0] = 4'd1; burst[1] = 4'd2; burst[2] = 4'd4; burst[3] = 4'd6; burst[4] = 4'd8;
    vectors = 0; miscompares = 0; cyc = 0;
    rst = 1'b0; ena = 1'b0; in_valid = 1'b0; in_data = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_step", step, 0);
    chk("rst_duty", duty, 0);
    chk("rst_pstart", period_start, 0);
    chk("rst_uflow", underflow, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", in_ready, 1);

    // 1: free run, no input; boundaries pulse at cycles 33 and 65
    ena = 1'b1;
    rst = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 66; k++) begin
      tick();
      chk("t1_step", step, (cyc >= 2 && cyc % 2 == 0) ? 1 : 0);
      chk("t1_pstart", period_start, (cyc == 33 || cyc == 65) ? 1 : 0);
      chk("t1_uflow", underflow, (cyc == 33 || cyc == 65) ? 1 : 0);
      chk("t1_duty", duty, 0);
    end

    // 2: push 3, 9, 15 back-to-back
    in_valid = 1'b1; in_data = 4'd3;
    tick(); chk("t2_level1", level, 1);
    in_data = 4'd9;
    tick(); chk("t2_level2", level, 2);
    in_data = 4'd15;
    tick(); chk("t2_level3", level, 3);
    in_valid = 1'b0;
    run_to(96);
    chk("t2_bstep", step, 1);
    chk("t2_duty_pre", duty, 0);
    tick();
    chk("t2_duty3", duty, 3);
    chk("t2_pstart", period_start, 1);
    chk("t2_uflow", underflow, 0);
    chk("t2_lvl_a", level, 2);
    run_to(129);
    chk("t2_duty9", duty, 9);
    chk("t2_lvl_b", level, 1);
    run_to(161);
    chk("t2_duty15", duty, 15);
    chk("t2_lvl_c", level, 0);

    // 3: five pushes, only four fit until the boundary pop
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = burst[i];
      tick();
      chk("t3_fill", level, i + 1);
    end
    chk("t3_full_rdy", in_ready, 0);
    in_data = burst[4];
    tick();
    chk("t3_held_lvl", level, 4);
    run_to(192);
    chk("t3_pre_lvl", level, 4);
    chk("t3_pre_rdy", in_ready, 0);
    tick();
    chk("t3_pop_duty", duty, 1);
    chk("t3_pop_lvl", level, 3);
    chk("t3_pop_rdy", in_ready, 1);
    tick();
    chk("t3_acc_lvl", level, 4);
    chk("t3_acc_rdy", in_ready, 0);
    in_valid = 1'b0;
    run_to(225); chk("t3_duty2", duty, 2);
    run_to(257); chk("t3_duty4", duty, 4);
    run_to(289); chk("t3_duty6", duty, 6);
    run_to(321); chk("t3_duty8", duty, 8);
    chk("t3_drained", level, 0);

    // 4: push into an empty FIFO in the boundary cycle
    run_to(352);
    chk("t4_bstep", step, 1);
    in_valid = 1'b1; in_data = 4'd7;
    tick();
    chk("t4_uflow", underflow, 1);
    chk("t4_pstart", period_start, 1);
    chk("t4_duty_hold", duty, 8);
    chk("t4_level", level, 1);
    in_valid = 1'b0;
    run_to(385);
    chk("t4_duty7", duty, 7);
    chk("t4_uflow_n", underflow, 0);
    chk("t4_pstart_n", period_start, 1);

    // 5: ena low for 10 cycles mid-period delays the boundary by 10
    run_to(395);
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_step_off", step, 0);
    end
    ena = 1'b1;
    tick();
    chk("t5_step_back", step, 1);
    run_to(417);
    chk("t5_no_early", period_start, 0);
    run_to(427);
    chk("t5_late_ps", period_start, 1);
    chk("t5_late_uf", underflow, 1);

    // 6: reset mid-period with two samples buffered
    in_valid = 1'b1; in_data = 4'hA;
    tick(); chk("t6_lvl1", level, 1);
    in_data = 4'hB;
    tick(); chk("t6_lvl2", level, 2);
    in_valid = 1'b0;
    run_to(440);
    chk("t6_pre_step", step, 1);
    chk("t6_pre_lvl", level, 2);
    rst = 1'b0;
    #1;
    chk("t6_step0", step, 0);
    chk("t6_duty0", duty, 0);
    chk("t6_lvl0", level, 0);
    chk("t6_rdy1", in_ready, 1);
    chk("t6_ps0", period_start, 0);
    chk("t6_uf0", underflow, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    tick(); chk("t6_first_n", step, 0);
    tick(); chk("t6_first_y", step, 1);
`ifdef PWM_FEEDER_UNDERFLOW_CNT_EN
    chk("t6_ucnt0", underflow_count, 0);
`endif
    run_to(33);
    chk("t6_uflow", underflow, 1);
    chk("t6_duty", duty, 0);
`ifdef PWM_FEEDER_UNDERFLOW_CNT_EN
    chk("t6_ucnt_pre", underflow_count, 0);
    tick();
    chk("t6_ucnt1", underflow_count, 1);
    run_to(66);
    chk("t6_ucnt2", underflow_count, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_sample_feeder.md
# pwm_sample_feeder

Upstream stage of the PWM output block. It buffers incoming audio samples in a small FIFO, generates the `step` pacing strobe, and presents each sample as a `duty` value. The duty value changes only at PWM period boundaries, so the downstream PWM never sees a mid-period change. It drives the downstream `step` and `duty` inputs directly, and both blocks share `clk`.

## Interface
- `N`, default 8: duty/sample width; must equal the downstream PWM `N`.
- `DEPTH`, default 4: FIFO entries, power of two, ≥2.
- `PRESCALE`, default 16: `clk` cycles per `step` pulse, ≥1.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `ena`  in  1  run enable for prescaler and phase tracking.
- `in_valid`  in  1  sample offered.
- `in_data`  in  N  sample value (unsigned).
- `in_ready`  out  1  FIFO can accept; equals `!full`.
- `step`  out  1  one-cycle pacing strobe to PWM.
- `duty`  out  N  registered duty to PWM.
- `period_start`  out  1  one-cycle pulse, high in the cycle `duty` takes its per-period update.
- `underflow`  out  1  one-cycle pulse: boundary reached with FIFO empty.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Reset values (rst=0):** `step`=0, `duty`=0, `period_start`=0, `underflow`=0, `level`=0, prescaler=0, phase=0, FIFO empty. `in_ready`=1.
- **Prescaler:** counts 0..PRESCALE-1 while `ena`=1, then wraps to 0.
  - `step` is registered and is 1 for exactly the cycle after the count reaches PRESCALE-1.
  - With PRESCALE=1, `step` is 1 every cycle while `ena` is high.
- **`ena`=0:** prescaler and phase hold, and `step`=0. FIFO push is unaffected. `duty` holds.
- **Phase counter:** N bits, increments on every `step`. It mirrors the downstream PWM counter; both are 0 after reset.
- **Boundary:** a `step` cycle with phase = 2^N−1. Phase wraps to 0. On the next edge:
  - If the FIFO is non-empty, pop the head into `duty` and set `period_start`=1.
  - If the FIFO is empty, `duty` holds its value (0 if no sample has ever been loaded), `underflow`=1, and `period_start`=1.
- **FIFO:**
  - Push on `in_valid && in_ready`.
  - `in_ready` does not depend on a same-cycle pop, so there is no push when full even if a pop occurs.
  - Empty FIFO with a push and a boundary in the same cycle: the pop sees empty and flags underflow; the pushed sample is stored and used at the next boundary. There is no bypass path.
  - Push and pop in the same cycle on a non-empty, non-full FIFO leaves `level` unchanged.
- **Arithmetic:** all pointers and counters wrap modulo their width. No arithmetic is applied to the sample; `duty = in_data` verbatim.

## Timing
- Period length is PRESCALE·2^N `clk` cycles while `ena`=1.
- `duty` updates one cycle after the boundary `step`. This is the same edge on which the downstream counter wraps to 0, so the new duty applies from count 0.
- Push-to-`level` latency: 1 cycle.
- Push-to-`duty` latency: until the next boundary, after all older entries have been consumed.
- Reset asserted mid-period clears everything asynchronously. Release is synchronous to the next `clk` edge, and the first `step` appears PRESCALE cycles after release.

## Configuration
- `PWM_FEEDER_UNDERFLOW_CNT_EN` defined:
  - Adds output `underflow_count` [15:0].
  - Increments on each `underflow` pulse and saturates at 16'hFFFF.
  - Cleared only by `rst`.
- Undefined: the port and counter are absent. The `underflow` pulse is unchanged.

## Structure
- Package `pwm_pkg`:
  - `PWM_N_DEFAULT` = 8
  - `UFLOW_CNT_W` = 16
  - typedef `pwm_level_t` for the phase/duty vector at the default width.
- Sub-module `sample_fifo`:
  - Parameterised by width and depth; synchronous FIFO with `push`, `pop`, `full`, `empty`, `level`.
  - Async active-low reset on `rst`.
- The top level holds the prescaler, phase counter, duty register and pulses.

## Test plan
Bench parameters: N=4, DEPTH=4, PRESCALE=2, so a period is 32 cycles.
1. Reset, `ena`=1, no input → `step` every 2nd cycle. `underflow` and `period_start` pulse every 32 cycles; `duty` stays 0.
2. Push 3, 9, 15 back-to-back → `level` reads 1, 2, 3. `duty` becomes 3, 9, 15 at successive boundaries, each one cycle after the phase-15 `step`.
3. Push 5 samples with no boundary → 4 accepted, `in_ready`=0 at `level`=4, 5th held. After the boundary pop, `in_ready`=1 and the 5th is accepted.
4. Empty FIFO, push 7 in the same cycle as the boundary → `underflow`=1, `duty` unchanged. `duty`=7 at the following boundary.
5. `ena`=0 for 10 cycles mid-period → `step`=0 and phase frozen. Period resumes and the boundary arrives exactly 10 cycles late.
6. Assert `rst` mid-period with `level`=2 → all outputs are 0 immediately. After release, the first `step` comes 2 cycles later. With the macro defined, `underflow_count` reads 0 and then counts boundaries.
